// File: rtl/cnt_pkg.sv
// -----------------------------------------------------------------------------
// cnt_pkg
// Shared types and constants for the counter-value UART transmitter.
//   tx_state_t    : transmitter frame state
//   UART_IDLE_LVL : line level while no frame is in flight (mark)
//   DATA_W        : payload width (counter width)
//   clog2         : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package cnt_pkg;

   localparam int   DATA_W        = 8;
   localparam logic UART_IDLE_LVL = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Smallest width w such that 2**w >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int width;
      width = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            width = i + 1;
         end else begin
            width = width;
         end
      end
      return width;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and raises tick during the last
// cycle of every bit period. clear holds the count at zero so the first period
// after clear is released is a full one.
// Ports:
//   clk   in  : system clock
//   rst   in  : synchronous active-high reset
//   clear in  : restart the bit period (held while the transmitter idles)
//   tick  out : high in the final cycle of each bit period (registered)
// -----------------------------------------------------------------------------
module baud_tick_gen
   import cnt_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int               CNT_W    = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             tick_r;

   assign cnt_inc_s = cnt_r + CNT_W'(1'b1);

   // Bit-period counter; tick_r is precomputed so it is high exactly while
   // cnt_r sits at LAST_CNT (LAST_CNT is never 0 since CLKS_PER_BIT >= 2).
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else if (cnt_r == LAST_CNT) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_inc_s;
         tick_r <= (cnt_inc_s == LAST_CNT);
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/count_uart_tx.sv
// -----------------------------------------------------------------------------
// count_uart_tx
// Serialises the live counter value as an 8N1 UART frame (LSB first). A frame
// is sent on a req pulse, or automatically (auto_en) when count_in differs from
// the last value sent. Triggers arriving mid-frame collapse into one follow-up
// frame that starts straight after the stop bit and carries the newest count.
// Ports:
//   clk        in  : system clock
//   rst        in  : synchronous active-high reset (aborts any frame)
//   count_in   in  : counter value [7:0]
//   auto_en    in  : send automatically when count_in != last value sent
//   req        in  : one-cycle request for a frame with the current count_in
//   tx         out : serial line, idle high
//   busy       out : high for every cycle of a frame in flight
//   frame_done out : high in the final cycle of the stop bit
// -----------------------------------------------------------------------------
module count_uart_tx
   import cnt_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] count_in,
   input  logic              auto_en,
   input  logic              req,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int               IDX_W    = clog2(DATA_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   tx_state_t         state_r,     state_s;
   logic [DATA_W-1:0] shift_r,     shift_s;
   logic [DATA_W-1:0] last_sent_r, last_sent_s;
   logic [IDX_W-1:0]  idx_r,       idx_s;
   logic              pending_r,   pending_s;
   logic              tx_r,        tx_s;
   logic              busy_r,      busy_s;

   logic              trig_s;
   logic              tick_s;
   logic              clear_s;
   logic [IDX_W-1:0]  idx_inc_s;

   assign trig_s    = req | (auto_en & (count_in != last_sent_r));
   assign clear_s   = (state_r == IDLE);
   assign idx_inc_s = idx_r + IDX_W'(1'b1);

   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_s),
      .tick  (tick_s)
   );

   // Next-state logic. tx_s/busy_s are the line values for the coming cycle so
   // that tx and busy come straight from flops. pending only remembers req: the
   // auto condition is re-evaluated against last_sent in the final stop cycle,
   // so a count that wanders and returns to last_sent does not cause a resend.
   always_comb begin
      state_s     = state_r;
      shift_s     = shift_r;
      last_sent_s = last_sent_r;
      idx_s       = idx_r;
      pending_s   = pending_r;
      tx_s        = tx_r;
      busy_s      = busy_r;
      case (state_r)
         IDLE: begin
            if (trig_s) begin
               state_s     = START;
               shift_s     = count_in;
               last_sent_s = count_in;
               idx_s       = '0;
               pending_s   = 1'b0;
               tx_s        = 1'b0;
               busy_s      = 1'b1;
            end else begin
               tx_s        = UART_IDLE_LVL;
               busy_s      = 1'b0;
            end
         end
         START: begin
            pending_s = pending_r | req;
            if (tick_s) begin
               state_s = DATA;
               idx_s   = '0;
               tx_s    = shift_r[0];
            end else begin
               tx_s    = 1'b0;
            end
         end
         DATA: begin
            pending_s = pending_r | req;
            if (tick_s) begin
               if (idx_r == LAST_IDX) begin
                  state_s = STOP;
                  tx_s    = UART_IDLE_LVL;
               end else begin
                  idx_s   = idx_inc_s;
                  tx_s    = shift_r[idx_inc_s];
               end
            end else begin
               tx_s = shift_r[idx_r];
            end
         end
         STOP: begin
            if (tick_s) begin
               if (pending_r || trig_s) begin
                  // Back-to-back frame: newest count wins, no idle cycle.
                  state_s     = START;
                  shift_s     = count_in;
                  last_sent_s = count_in;
                  idx_s       = '0;
                  pending_s   = 1'b0;
                  tx_s        = 1'b0;
                  busy_s      = 1'b1;
               end else begin
                  state_s     = IDLE;
                  pending_s   = 1'b0;
                  tx_s        = UART_IDLE_LVL;
                  busy_s      = 1'b0;
               end
            end else begin
               pending_s = pending_r | req;
               tx_s      = UART_IDLE_LVL;
            end
         end
         default: begin
            state_s   = IDLE;
            pending_s = 1'b0;
            tx_s      = UART_IDLE_LVL;
            busy_s    = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         shift_r     <= '0;
         last_sent_r <= '0;
         idx_r       <= '0;
         pending_r   <= 1'b0;
         tx_r        <= UART_IDLE_LVL;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         shift_r     <= shift_s;
         last_sent_r <= last_sent_s;
         idx_r       <= idx_s;
         pending_r   <= pending_s;
         tx_r        <= tx_s;
         busy_r      <= busy_s;
      end
   end

   assign tx   = tx_r;
   assign busy = busy_r;
   // Decode of two flops (state and the registered tick): no input path.
   assign frame_done = (state_r == STOP) && tick_s;

endmodule

// File: tb/tb_count_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_count_uart_tx
// Directed bench for count_uart_tx with CLKS_PER_BIT = 4 (40-cycle frames).
// Outputs are sampled 1 time unit after each rising edge; inputs change there.
// -----------------------------------------------------------------------------
module tb_count_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] count_in;
   logic       auto_en;
   logic       req;
   logic       tx;
   logic       busy;
   logic       frame_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   count_uart_tx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .count_in   (count_in),
      .auto_en    (auto_en),
      .req        (req),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tx"},   32'(tx),         32'd1);
      check({tag, "_busy"}, 32'(busy),       32'd0);
      check({tag, "_done"}, 32'(frame_done), 32'd0);
   endtask

   // Called in cycle 0 of a frame (start bit already on the line); checks all
   // 40 cycles and returns in the last one. Up to three count_in changes are
   // applied after the checks of cycle at0/at1/at2 (-1 = unused).
   task automatic frame(input logic [7:0] v, input string tag,
                        input int at0, input logic [7:0] v0,
                        input int at1, input logic [7:0] v1,
                        input int at2, input logic [7:0] v2);
      for (int i = 0; i < FRAME; i++) begin
         logic exp_tx;
         if (i < CPB) begin
            exp_tx = 1'b0;
         end else if (i < 9 * CPB) begin
            exp_tx = v[(i - CPB) / CPB];
         end else begin
            exp_tx = 1'b1;
         end
         check($sformatf("%s_tx%0d", tag, i),   32'(tx),         32'(exp_tx));
         check($sformatf("%s_busy%0d", tag, i), 32'(busy),       32'd1);
         check($sformatf("%s_done%0d", tag, i), 32'(frame_done), 32'(i == FRAME - 1));
         if (i == at0) count_in = v0;
         if (i == at1) count_in = v1;
         if (i == at2) count_in = v2;
         if (i != FRAME - 1) step();
      end
   endtask

   initial begin
      rst      = 1'b1;
      auto_en  = 1'b1;
      req      = 1'b0;
      count_in = 8'h00;

      // Reset state
      step();
      check_idle("rst");
      step();
      check_idle("rst2");
      rst = 1'b0;

      // count matches last_sent after reset: no frame
      for (int i = 0; i < 100; i++) begin
         step();
         check_idle($sformatf("quiet%0d", i));
      end

      // Auto frame A5; mid-frame steps collapse into one follow-up frame of 03
      count_in = 8'hA5;
      step();
      frame(8'hA5, "a5", 5, 8'h01, 10, 8'h02, 15, 8'h03);
      step();
      frame(8'h03, "fup", -1, 8'h00, -1, 8'h00, -1, 8'h00);
      step();
      check_idle("after_fup");
      step();
      check_idle("after_fup2");

      // auto disabled: no frame on change; req sends, second req resends
      auto_en  = 1'b0;
      count_in = 8'h3C;
      step();
      check_idle("auto_off");
      step();
      check_idle("auto_off2");
      req = 1'b1;
      step();
      req = 1'b0;
      frame(8'h3C, "req1", -1, 8'h00, -1, 8'h00, -1, 8'h00);
      step();
      check_idle("req1_end");
      req = 1'b1;
      step();
      req = 1'b0;
      frame(8'h3C, "req2", -1, 8'h00, -1, 8'h00, -1, 8'h00);
      step();
      check_idle("req2_end");

      // Reset in DATA bit 3, then auto frame because last_sent returned to 00
      auto_en = 1'b1;
      req     = 1'b1;
      step();
      req = 1'b0;
      repeat (17) step();
      check("mid_tx",   32'(tx),   32'd1);
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      check_idle("abort");
      rst = 1'b0;
      step();
      frame(8'h3C, "post_rst", -1, 8'h00, -1, 8'h00, -1, 8'h00);
      step();
      check_idle("post_rst_end");

      // Wrap FF -> 00, then a change that returns to last_sent: no resend
      count_in = 8'hFF;
      step();
      frame(8'hFF, "ff", 20, 8'h00, -1, 8'h00, -1, 8'h00);
      step();
      frame(8'h00, "wrap", 10, 8'h05, 20, 8'h00, -1, 8'h00);
      for (int i = 0; i < 5; i++) begin
         step();
         check_idle($sformatf("no_return%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/count_uart_tx.md
Name: count_uart_tx

Overview:
- Downstream consumer of the 8-bit counter output. It serialises the current count onto a single UART TX line (8N1, LSB first), so the value can be read off a pin on the TinyTapeout board.
- Sends a frame automatically whenever the count changes (when enabled), or on an explicit request pulse.
- Output drives one uio_out bit; inputs come from the counter's q bus and ui_in control bits.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit period; legal range 2..65535.
- DATA_W, 8, width of the count value and of the serial payload; fixed at 8 for this revision.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: synchronous, active-high
- count_in  input  8  live counter value (counter q)
- auto_en  input  1  1 = send a frame automatically when count_in differs from the last value sent
- req  input  1  single-cycle pulse; request a frame with the current count_in
- tx  output  1  UART serial line, idle high
- busy  output  1  high while a frame is in flight
- frame_done  output  1  one-cycle pulse in the last cycle of the stop bit

Behaviour:
- Reset values (rst sampled high on a clk edge):
  - tx=1, busy=0, frame_done=0.
  - FSM=IDLE, pending=0, last_sent=8'h00, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame immediately; tx returns to 1 on the next edge. No partial stop bit is sent.
- Trigger, evaluated every cycle: trig = req | (auto_en & (count_in != last_sent)).
- IDLE + trig:
  - Capture count_in into shift_reg, set last_sent=count_in, move to START.
  - busy=1 and tx=0 from the next cycle. Latency from trigger to the start-bit edge is exactly 1 clk.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
- DATA: tx=shift_reg[idx] for CLKS_PER_BIT cycles per bit, LSB first. After idx=7 completes, move to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 in the final cycle, then IDLE and busy=0.
- Total frame length is exactly 10*CLKS_PER_BIT cycles. busy is high for exactly that many cycles.
- Trigger while not IDLE:
  - Sets pending=1; the payload is not captured yet.
  - When STOP completes with pending=1, go directly to START (no idle cycle). busy stays 1, pending clears, and the payload is count_in as sampled in that final STOP cycle, so the latest value wins.
  - Multiple triggers during one frame collapse into a single follow-up frame.
- Change-detect without repeats: auto trigger compares against last_sent, not the previous cycle. A count that changes and returns to last_sent before IDLE produces no follow-up frame unless req also fired.
- req while IDLE and count_in == last_sent still sends a frame (forced resend).
- Counter wrap-around (8'hFF -> 8'h00) is an ordinary change. No special handling.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state or bit advance. Width is clog2(CLKS_PER_BIT).
- All outputs are registered; tx has no combinational path from the inputs.

Decomposition:
- Package cnt_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}
  - UART_IDLE_LVL=1'b1
  - DATA_W localparam
  - shared clog2 helper
- Sub-module baud_tick_gen(clk, rst, clear, tick):
  - Parameterised by CLKS_PER_BIT.
  - Asserts tick on the last cycle of each bit period.
  - clear restarts the count.
- FSM, shift register, pending logic and last_sent stay in count_uart_tx.

Test Plan (CLKS_PER_BIT=4):
- Reset, then count_in=8'h00, auto_en=1, no req, for 100 cycles -> tx=1 and busy=0 throughout; no frame.
- count_in changes to 8'hA5 with auto_en=1 -> tx=0 one cycle later. Each 4-cycle bit is then 1,0,1,0,0,1,0,1, followed by stop=1. frame_done pulses in cycle 40; busy is high for 40 cycles.
- During the 8'hA5 frame, count_in steps 8'h01, 8'h02, 8'h03 -> exactly one follow-up frame carrying 8'h03, starting the cycle after the first frame's stop ends, with busy continuously high for 80 cycles.
- auto_en=0, count_in=8'h3C, req pulse -> one frame with payload 8'h3C. A second req with count_in unchanged -> a second identical frame.
- rst asserted in the DATA state at bit 3 -> the next cycle shows tx=1, busy=0 and no frame_done. With auto_en=1 and count_in=8'h3C, a new frame starts 1 cycle after rst deasserts, because last_sent was reset to 8'h00.
- count_in wraps from 8'hFF to 8'h00 with auto_en=1 -> frame 8'hFF followed by frame 8'h00.
